axi_rd_burst_sched: RTL and testbench
=====================================

# axi_rd_burst_sched

Read-side burst scheduler for the DMA controller: accepts one copy command (start byte address, word count), splits it into AXI4 INCR read bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and drives them one at a time into the AXI read channels of `axi_slave`. Returned beats are forwarded to a downstream stream sink (write-side FIFO) with backpressure. The block reports completion and sticky error status per command.

## Interface
- `ADDR_WD`, 32, address width (bytes)
- `DATA_WD`, 32, data width; BYTES = DATA_WD/8
- `LEN_WD`, 16, command word-count width
- `MAX_BURST`, 16, max beats per burst (1..256)
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when both high
- `cmd_addr`  in  ADDR_WD  start byte address; low log2(BYTES) bits ignored (forced 0)
- `cmd_words`  in  LEN_WD  number of DATA_WD beats to read; 0 allowed
- `M_AXI_ARVALID`  out  1  read address valid
- `M_AXI_ARADDR`  out  ADDR_WD  burst start address
- `M_AXI_ARLEN`  out  8  beats-1
- `M_AXI_ARSIZE`  out  3  constant log2(BYTES)
- `M_AXI_ARBURST`  out  2  constant 2'b01 (INCR)
- `M_AXI_ARREADY`  in  1  slave address ready
- `M_AXI_RVALID`  in  1  read data valid
- `M_AXI_RDATA`  in  DATA_WD  read data
- `M_AXI_RRESP`  in  2  read response
- `M_AXI_RLAST`  in  1  last beat of burst
- `M_AXI_RREADY`  out  1  read data ready
- `out_valid`  out  1  forwarded beat valid
- `out_data`  out  DATA_WD  forwarded beat
- `out_last`  out  1  final beat of whole command
- `out_ready`  in  1  sink ready
- `done`  out  1  one-cycle pulse at command end
- `err`  out  1  sticky error for current command; valid with `done`, cleared on next command accept

## Operation
- FSM IDLE, ADDR, DATA, DONE. Registers: cur_addr (ADDR_WD), remaining (LEN_WD), beats (9 bit), beat_cnt (9 bit).
- IDLE: `cmd_ready`=1. On accept, latch aligned cur_addr and remaining=cmd_words, clear err; if cmd_words==0 go DONE, else go ADDR.
- ADDR: beats = min(remaining, MAX_BURST, (4096 - cur_addr[11:0])/BYTES). Registered `ARVALID`=1, ARADDR=cur_addr, ARLEN=beats-1, all held stable until ARREADY. On handshake go DATA, beat_cnt=0.
- DATA: `RREADY` = `out_ready`; `out_valid` = `RVALID`; `out_data` = `RDATA` (combinational pass-through). Each R handshake increments beat_cnt. RRESP≠0 sets err; data still forwarded.
- The internal beat count is the authority for burst end. If RLAST differs from (beat_cnt==beats-1) on any beat, err is set.
- On the last beat of a burst: cur_addr += beats*BYTES (mod 2^ADDR_WD), remaining -= beats. If remaining==0 go DONE, else ADDR.
- `out_last` = out_valid && remaining==beats && beat_cnt==beats-1.
- DONE: `done`=1 for one cycle, then IDLE.
- Only one burst is outstanding at a time.

## Timing
- Reset values: state IDLE, ARVALID 0, ARADDR 0, ARLEN 0, RREADY 0, out_valid 0, out_last 0, done 0, err 0. `cmd_ready` is 1 from the first cycle after reset.
- Command accepted at cycle T: ARVALID rises at T+1.
- AR handshake at cycle A: RREADY may assert from A+1.
- Last beat of a non-final burst at B: next ARVALID at B+1.
- Last beat of the final burst at B: done at B+1, cmd_ready at B+2.
- Zero-length command accepted at T: done at T+1, no AR issued.
- Reset mid-operation: the next cycle is IDLE with ARVALID=0 and RREADY=0. In-flight beats are dropped, and no done pulse is generated.
- `RREADY` is 0 in every state except DATA.

## Test plan
- addr 0x100, words 4, ARREADY=1, out_ready=1 -> one AR {0x100, len 3, size 2, burst 1}; 4 out beats; out_last on beat 4; done next cycle; err 0.
- addr 0x0, words 40, MAX_BURST 16 -> ARs {0x00, len 15}, {0x40, len 15}, {0x80, len 7}; exactly 40 beats; out_last only on beat 40.
- addr 0xFF8, words 4 -> ARs {0xFF8, len 1}, {0x1000, len 1}; no burst crosses 0x1000.
- ARREADY low for 5 cycles -> ARVALID, ARADDR and ARLEN stable throughout. Then out_ready toggling 1/0 -> RREADY mirrors it, and the sink sees 4 in-order beats with none lost or duplicated.
- RRESP=2'b10 on beat 2 of 4 -> all 4 beats forwarded, err=1 with done. Second case: cmd_words=0 -> done at T+1, no ARVALID.
- rst pulsed during the DATA phase of a 40-word command -> next cycle ARVALID=0, RREADY=0, cmd_ready=1, done never pulses. A following 4-word command completes normally.

Source files
------------

// File: rtl/axi_rd_burst_sched.sv
// axi_rd_burst_sched: splits a copy command into 4KB-safe AXI4 INCR read bursts and forwards beats downstream
module axi_rd_burst_sched #(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int LEN_WD    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [LEN_WD-1:0]  cmd_words,
  output logic               M_AXI_ARVALID,
  output logic [ADDR_WD-1:0] M_AXI_ARADDR,
  output logic [7:0]         M_AXI_ARLEN,
  output logic [2:0]         M_AXI_ARSIZE,
  output logic [1:0]         M_AXI_ARBURST,
  input  logic               M_AXI_ARREADY,
  input  logic               M_AXI_RVALID,
  input  logic [DATA_WD-1:0] M_AXI_RDATA,
  input  logic [1:0]         M_AXI_RRESP,
  input  logic               M_AXI_RLAST,
  output logic               M_AXI_RREADY,
  output logic               out_valid,
  output logic [DATA_WD-1:0] out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               done,
  output logic               err
);
  localparam int BYTES = DATA_WD / 8;
  localparam int AW = $clog2(BYTES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]         state;
  logic [ADDR_WD-1:0] cur_addr;
  logic [LEN_WD-1:0]  remaining;
  logic [8:0]         beats, beat_cnt, beats_c;
  logic [12:0]        room, lim;
  logic               r_hs, last_beat;
  // beats left before the next 4KB page, then capped by MAX_BURST and the words still owed
  assign room      = (13'h1000 - {1'b0, cur_addr[11:0]}) >> AW;
  assign lim       = 13'(MAX_BURST) < room ? 13'(MAX_BURST) : room;
  assign beats_c   = 32'(lim) < 32'(remaining) ? 9'(lim) : 9'(remaining);
  assign last_beat = beat_cnt == beats - 9'd1;
  assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
  assign cmd_ready     = state == IDLE;
  assign done          = state == DONE;
  assign M_AXI_ARVALID = state == ADDR;
  assign M_AXI_ARADDR  = cur_addr;
  assign M_AXI_ARLEN   = state == ADDR ? 8'(beats_c - 9'd1) : 8'd0;
  assign M_AXI_ARSIZE  = 3'(AW);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_RREADY  = state == DATA && out_ready;
  assign out_valid     = state == DATA && M_AXI_RVALID;
  assign out_data      = M_AXI_RDATA;
  assign out_last      = out_valid && remaining == LEN_WD'(beats) && last_beat;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cur_addr  <= cmd_addr & ~ADDR_WD'(BYTES - 1);
          remaining <= cmd_words;
          err       <= 1'b0;
          state     <= cmd_words == '0 ? DONE : ADDR;
        end
        ADDR: if (M_AXI_ARREADY) begin
          beats    <= beats_c;
          beat_cnt <= '0;
          state    <= DATA;
        end
        DATA: if (r_hs) begin
          if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != last_beat) err <= 1'b1;
          if (last_beat) begin
            cur_addr  <= cur_addr + (ADDR_WD'(beats) << AW);
            remaining <= remaining - LEN_WD'(beats);
            state     <= remaining == LEN_WD'(beats) ? DONE : ADDR;
          end else begin
            beat_cnt <= beat_cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// tb_axi_rd_burst_sched: randomized scoreboard bench with a memory-model AXI slave and a burst-splitting reference model
module tb_axi_rd_burst_sched;
  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [31:0] data; bit last;} beat_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [31:0] cmd_addr = 0;
  logic [15:0] cmd_words = 0;
  logic arvalid, arready, rvalid, rlast, rready;
  logic [31:0] araddr, rdata, out_data;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp;
  logic out_valid, out_last, out_ready, done, err;
  int checks = 0, errors = 0;
  ar_t ar_q[$];
  beat_t beat_q[$];
  bit err_q[$];
  bit quiet = 1;
  int armode = 0, rmode = 0, omode = 0;
  int err_at = -1, flip_at = -1, gbeat = 0, beats_seen = 0;
  int flush_req = 0, flush_ack = 0;
  axi_rd_burst_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARREADY(arready),
    .M_AXI_RVALID(rvalid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RREADY(rready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] dfun(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  // reference: walk the command in page/burst-capped chunks
  task automatic model(input logic [31:0] addr, input int words);
    logic [31:0] a;
    int n, room, b;
    a = addr & ~32'h3;
    n = words;
    while (n > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = n < 16 ? n : 16;
      if (room < b) b = room;
      ar_q.push_back('{a, 8'(b - 1)});
      for (int i = 0; i < b; i++) beat_q.push_back('{dfun(a + 32'(4 * i)), (n == b) && (i == b - 1)});
      a = a + 32'(4 * b);
      n = n - b;
    end
  endtask
  // AXI slave: memory returning dfun(address), with optional RRESP/RLAST corruption
  initial begin
    ar_t rq[$];
    int rbeat = 0, wcnt = 0;
    bit held = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(negedge clk);
      held = 0;
      if (flush_req != flush_ack) begin
        flush_ack = flush_req;
        rq.delete();
        rbeat = 0;
        wcnt = 0;
      end else begin
        if (arvalid && arready) begin
          rq.push_back('{araddr, arlen});
          wcnt = 0;
        end else if (arvalid) wcnt++;
        held = rvalid && !rready;
        if (rvalid && rready && rq.size() > 0) begin
          gbeat++;
          if (rbeat == int'(rq[0].len)) begin
            void'(rq.pop_front());
            rbeat = 0;
          end else rbeat++;
        end
      end
      @(posedge clk);
      #1;
      arready = armode == 0 ? 1'b1 : armode == 1 ? 1'($urandom % 2) : (wcnt >= 5);
      if (!held) begin
        if (rq.size() > 0 && (rmode == 0 || $urandom % 4 != 0)) begin
          rvalid = 1;
          rdata = dfun(rq[0].addr + 32'(4 * rbeat));
          rlast = (rbeat == int'(rq[0].len)) ^ (gbeat == flip_at);
          rresp = gbeat == err_at ? 2'b10 : 2'b00;
        end else begin
          rvalid = 0;
          rdata = $urandom;
          rlast = 0;
          rresp = 0;
        end
      end
    end
  end
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = omode == 0 ? 1'b1 : omode == 1 ? !out_ready : 1'($urandom % 2);
    end
  end
  // AR monitor: in-order burst compare plus hold-while-stalled stability
  initial begin
    bit pv = 0;
    logic [31:0] pa = 0;
    logic [7:0] pl = 0;
    forever begin
      @(negedge clk);
      if (quiet) pv = 0;
      else begin
        if (pv) chk(arvalid && araddr == pa && arlen == pl, "ar_stable", {arvalid, araddr, arlen}, {1'b1, pa, pl});
        if (arvalid && arready) begin
          if (ar_q.size() == 0) chk(0, "ar_unexpected", araddr, 0);
          else begin
            ar_t e;
            e = ar_q.pop_front();
            chk(araddr == e.addr && arlen == e.len, "ar_burst", {araddr, arlen}, {e.addr, e.len});
            chk(arsize == 3'd2 && arburst == 2'b01, "ar_size_burst", {arsize, arburst}, {3'd2, 2'b01});
          end
        end
        pv = arvalid && !arready;
        pa = araddr;
        pl = arlen;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!quiet) begin
      if (out_valid) chk(rready == out_ready, "rready_mirror", rready, out_ready);
      if (out_valid && out_ready) begin
        beats_seen++;
        if (beat_q.size() == 0) chk(0, "beat_unexpected", out_data, 0);
        else begin
          beat_t e;
          e = beat_q.pop_front();
          chk(out_data == e.data && out_last == e.last, "beat", {out_last, out_data}, {e.last, e.data});
        end
      end
      if (done) begin
        if (err_q.size() == 0) chk(0, "done_unexpected", done, 0);
        else begin
          bit e;
          e = err_q.pop_front();
          chk(err == e, "done_err", err, e);
        end
      end
    end
  end
  task automatic run_cmd(input logic [31:0] addr, input int words, input int eidx, input int fidx,
                         input int am, input int om, input int rm);
    int n;
    bit seen;
    model(addr, words);
    err_q.push_back(eidx >= 0 || fidx >= 0);
    armode = am; omode = om; rmode = rm;
    err_at = eidx >= 0 ? gbeat + eidx : -1;
    flip_at = fidx >= 0 ? gbeat + fidx : -1;
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_addr = addr; cmd_words = 16'(words);
    @(negedge clk);
    chk(cmd_ready == 1, "cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0; cmd_addr = $urandom; cmd_words = 16'($urandom);
    @(negedge clk);
    if (words == 0) chk(done == 1 && arvalid == 0, "zero_done_t1", {done, arvalid}, 2'b10);
    else chk(arvalid == 1, "ar_rise_t1", arvalid, 1);
    seen = done;
    n = 0;
    while (!seen && n < 4000) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    if (!seen) chk(0, "done_timeout", n, 4000);
    chk(ar_q.size() == 0 && beat_q.size() == 0, "queues_drained", {ar_q.size(), beat_q.size()}, 0);
    @(negedge clk);
    chk(cmd_ready == 1 && done == 0 && rready == 0, "idle_after_done", {cmd_ready, done, rready}, 3'b100);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({arvalid, araddr, arlen, rready, out_valid, out_last, done, err} == '0, "reset_outputs",
        {arvalid, araddr, arlen, rready, out_valid, out_last, done, err}, 0);
    chk(cmd_ready == 1, "reset_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 0;
    quiet = 0;
    run_cmd(32'h100, 4, -1, -1, 0, 0, 0);
    run_cmd(32'h0, 40, -1, -1, 0, 0, 0);
    run_cmd(32'hFF8, 4, -1, -1, 0, 0, 0);
    run_cmd(32'h200, 4, -1, -1, 2, 1, 0);
    run_cmd(32'h300, 4, 1, -1, 0, 0, 0);
    run_cmd(32'h400, 0, -1, -1, 0, 0, 0);
    run_cmd(32'h503, 20, -1, 3, 1, 2, 1);
    run_cmd(32'hFFFF_FFF8, 4, -1, -1, 0, 0, 0);
    // reset in the middle of the first burst of a 40-word command
    model(32'h0, 40);
    err_q.push_back(0);
    armode = 0; omode = 0; rmode = 0; err_at = -1; flip_at = -1;
    n = beats_seen;
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_addr = 0; cmd_words = 40;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    for (int i = 0; i < 500 && beats_seen < n + 10; i++) @(negedge clk);
    chk(beats_seen >= n + 10, "reset_test_progress", beats_seen - n, 10);
    @(posedge clk);
    #1;
    quiet = 1;
    rst = 1;
    flush_req++;
    @(negedge clk);
    ar_q.delete();
    beat_q.delete();
    err_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk(arvalid == 0 && rready == 0 && cmd_ready == 1 && done == 0, "post_reset_idle",
        {arvalid, rready, cmd_ready, done}, 4'b0010);
    quiet = 0;
    repeat (30) @(negedge clk);
    run_cmd(32'h100, 4, -1, -1, 0, 0, 0);
    for (int k = 0; k < 25; k++) begin
      logic [31:0] a;
      int w, e, f;
      a = $urandom_range(0, 3) == 0 ? 32'h1000 * 32'($urandom_range(1, 8)) - 32'(4 * $urandom_range(0, 24))
                                    : ($urandom & 32'h0000_7FFF);
      w = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 60);
      e = (w > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, w - 1) : -1;
      f = (w > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, w - 1) : -1;
      run_cmd(a, w, e, f, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
